// File: rtl/kbd_char_buffer_pkg.sv
// Shared definitions for the keyboard character buffer.
// Holds the scan-code set 2 prefix and modifier codes, the decoder state
// encoding and the control-character ASCII values.
package kbd_pkg;

  // Scan-code set 2 prefixes and modifier keys
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  // Extended (E0-prefixed) keypad keys that produce characters
  localparam logic [7:0] SC_KP_ENTER = 8'h5A;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  // ASCII control characters
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;

  // Prefix-tracking decoder state
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } kbd_state_e;

endpackage

// File: rtl/kbd_char_buffer_if.sv
// Bus bundle between the keyboard character buffer and its neighbours.
//   Receiver side : rda, data
//   CPU side      : rd, clr_ovf, ascii, char_avail, count, overflow
//   Status        : shift, caps, dbg_state (decoder state, for observation)
// Handshake: a byte is offered by a rising edge of rda with data valid while
// rda is high (no back-pressure; the buffer always accepts). On the CPU side
// ascii is valid whenever char_avail is high, and each cycle with rd high and
// char_avail high consumes exactly one character; rd while empty is a no-op.
interface kbd_char_buffer_if
  import kbd_pkg::*;
#(
  parameter int AW = 4
);
  logic          rda;
  logic [7:0]    data;
  logic          rd;
  logic          clr_ovf;
  logic [7:0]    ascii;
  logic          char_avail;
  logic [AW:0]   count;
  logic          overflow;
  logic          shift;
  logic          caps;
  kbd_state_e    dbg_state;

  modport slave (
    input  rda, data, rd, clr_ovf,
    output ascii, char_avail, count, overflow, shift, caps, dbg_state
  );

  modport master (
    output rda, data, rd, clr_ovf,
    input  ascii, char_avail, count, overflow, shift, caps, dbg_state
  );
endinterface

// File: rtl/kbd_char_buffer_ascii_lut.sv
// Combinational scan-code set 2 to ASCII translation.
//   code_i  : make code
//   shift_i : a shift key is held
//   caps_i  : caps-lock toggle state
//   ascii_o : translated character, 0x00 for unmapped codes
// Letters flip case on shift XOR caps; digits and punctuation only follow shift.
module kbd_ascii_lut
  import kbd_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [7:0] ascii_o
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       is_letter;

  always_comb begin
    lo        = 8'h00;
    hi        = 8'h00;
    is_letter = 1'b0;
    case (code_i)
      // Letters: only the lowercase glyph is listed, uppercase derived below
      8'h1C: begin lo = "a"; is_letter = 1'b1; end
      8'h32: begin lo = "b"; is_letter = 1'b1; end
      8'h21: begin lo = "c"; is_letter = 1'b1; end
      8'h23: begin lo = "d"; is_letter = 1'b1; end
      8'h24: begin lo = "e"; is_letter = 1'b1; end
      8'h2B: begin lo = "f"; is_letter = 1'b1; end
      8'h34: begin lo = "g"; is_letter = 1'b1; end
      8'h33: begin lo = "h"; is_letter = 1'b1; end
      8'h43: begin lo = "i"; is_letter = 1'b1; end
      8'h3B: begin lo = "j"; is_letter = 1'b1; end
      8'h42: begin lo = "k"; is_letter = 1'b1; end
      8'h4B: begin lo = "l"; is_letter = 1'b1; end
      8'h3A: begin lo = "m"; is_letter = 1'b1; end
      8'h31: begin lo = "n"; is_letter = 1'b1; end
      8'h44: begin lo = "o"; is_letter = 1'b1; end
      8'h4D: begin lo = "p"; is_letter = 1'b1; end
      8'h15: begin lo = "q"; is_letter = 1'b1; end
      8'h2D: begin lo = "r"; is_letter = 1'b1; end
      8'h1B: begin lo = "s"; is_letter = 1'b1; end
      8'h2C: begin lo = "t"; is_letter = 1'b1; end
      8'h3C: begin lo = "u"; is_letter = 1'b1; end
      8'h2A: begin lo = "v"; is_letter = 1'b1; end
      8'h1D: begin lo = "w"; is_letter = 1'b1; end
      8'h22: begin lo = "x"; is_letter = 1'b1; end
      8'h35: begin lo = "y"; is_letter = 1'b1; end
      8'h1A: begin lo = "z"; is_letter = 1'b1; end
      // Digit row
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h45: begin lo = "0"; hi = ")"; end
      // Punctuation
      8'h0E: begin lo = 8'h60; hi = "~"; end
      8'h4E: begin lo = "-";   hi = "_"; end
      8'h55: begin lo = "=";   hi = "+"; end
      8'h54: begin lo = "[";   hi = "{"; end
      8'h5B: begin lo = "]";   hi = "}"; end
      8'h5D: begin lo = 8'h5C; hi = "|"; end
      8'h4C: begin lo = ";";   hi = ":"; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = ",";   hi = "<"; end
      8'h49: begin lo = ".";   hi = ">"; end
      8'h4A: begin lo = "/";   hi = "?"; end
      // Shift-independent keys
      8'h29: begin lo = 8'h20;     hi = 8'h20;     end
      8'h5A: begin lo = ASCII_CR;  hi = ASCII_CR;  end
      8'h66: begin lo = ASCII_BS;  hi = ASCII_BS;  end
      8'h0D: begin lo = ASCII_TAB; hi = ASCII_TAB; end
      8'h76: begin lo = ASCII_ESC; hi = ASCII_ESC; end
      default: ;
    endcase

    if (is_letter) begin
      hi      = lo - 8'h20;
      ascii_o = (shift_i ^ caps_i) ? hi : lo;
    end else begin
      ascii_o = shift_i ? hi : lo;
    end
  end

endmodule

// File: rtl/kbd_char_buffer.sv
// Keyboard character buffer: decodes PS/2 scan-code set 2 bytes into ASCII
// and queues them in a first-word-fall-through FIFO for the CPU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : kbd_char_buffer_if slave (rda/data in, rd/clr_ovf in,
//              ascii/char_avail/count/overflow/shift/caps/dbg_state out)
module kbd_char_buffer
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
)(
  input  logic             clk,
  input  logic             rst,
  kbd_char_buffer_if.slave bus
);

  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic            rda_q;
  logic            new_byte;
  kbd_state_e      state_q;
  logic            shift_q;
  logic            caps_q;
  logic [7:0]      lut_char;
  logic            push;
  logic [7:0]      push_char;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q;
  logic            pop, full, push_ok, drop;

  // Only the rising edge of rda counts, so a level-style rda decodes once.
  assign new_byte = bus.rda & ~rda_q;

  kbd_ascii_lut u_lut (
    .code_i  (bus.data),
    .shift_i (shift_q),
    .caps_i  (caps_q),
    .ascii_o (lut_char)
  );

  // Decoder: prefix tracking plus shift/caps modifiers
  always_ff @(posedge clk) begin
    if (rst) begin
      rda_q   <= 1'b0;
      state_q <= ST_IDLE;
      shift_q <= 1'b0;
      caps_q  <= 1'b0;
    end else begin
      rda_q <= bus.rda;
      if (new_byte) begin
        case (state_q)
          ST_IDLE: begin
            if (bus.data == SC_EXT)
              state_q <= ST_EXT;
            else if (bus.data == SC_BRK)
              state_q <= ST_BREAK;
            else if (bus.data == SC_LSHIFT || bus.data == SC_RSHIFT)
              shift_q <= 1'b1;
            else if (bus.data == SC_CAPS)
              caps_q <= ~caps_q;
          end
          ST_BREAK: begin
            if (bus.data == SC_LSHIFT || bus.data == SC_RSHIFT)
              shift_q <= 1'b0;
            state_q <= ST_IDLE;
          end
          ST_EXT: begin
            state_q <= (bus.data == SC_BRK) ? ST_EXT_BREAK : ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Character produced by this byte, written into the FIFO on the same edge
  always_comb begin
    push      = 1'b0;
    push_char = lut_char;
    if (new_byte) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.data != SC_EXT && bus.data != SC_BRK &&
              bus.data != SC_LSHIFT && bus.data != SC_RSHIFT &&
              bus.data != SC_CAPS && lut_char != 8'h00)
            push = 1'b1;
        end
        ST_EXT: begin
          if (bus.data == SC_KP_ENTER) begin
            push      = 1'b1;
            push_char = ASCII_CR;
          end else if (bus.data == SC_KP_SLASH) begin
            push      = 1'b1;
            push_char = ASCII_SLASH;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO control. A pop frees a slot in the same cycle, so a push while
  // full still succeeds when rd is high; an empty FIFO ignores the pop.
  assign full    = (count_q == CNT_FULL);
  assign pop     = bus.rd && (count_q != '0);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)
      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop)     rptr_q <= rptr_q + PTR_ONE;
      count_q <= count_d;
      // A drop in the same cycle as clr_ovf keeps the flag set
      if (drop)
        overflow_q <= 1'b1;
      else if (bus.clr_ovf)
        overflow_q <= 1'b0;
    end
  end

  // Storage is not reset; the empty-gate on ascii hides stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_char;
  end

  assign bus.ascii      = (count_q != '0) ? mem_q[rptr_q] : 8'h00;
  assign bus.char_avail = (count_q != '0);
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.shift      = shift_q;
  assign bus.caps       = caps_q;
  assign bus.dbg_state  = state_q;

endmodule
